// File: rtl/mem_pkg.sv
// Shared definitions for the handshaked data memory: access sizes, FSM states
// and the legal read-latency window.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 8;

  // Keeps an out-of-window latency parameter from breaking the counter width.
  function automatic int lat_clamp(input int lat);
    if (lat < READ_LAT_MIN) return READ_LAT_MIN;
    if (lat > READ_LAT_MAX) return READ_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/mem_if.sv
// Request/response bus between the MEMORY-stage control path and the data memory.
interface mem_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store write-enables and replicated write data, load
// extraction with sign/zero extension, and the misalignment flag.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        misaligned
);

  logic [31:0] lane_sh;
  logic        ext;

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    be         = '0;
    wword      = '0;
    rdata      = '0;
    misaligned = 1'b0;
    ext        = 1'b0;
    lane_sh    = rword >> {offset, 3'b000};
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << offset;
        wword = {4{wdata[7:0]}};
        ext   = ~is_unsigned & lane_sh[7];
        rdata = {{24{ext}}, lane_sh[7:0]};
      end
      SZ_HALF: begin
        misaligned = offset[0];
        if (!offset[0]) begin
          be    = offset[1] ? 4'b1100 : 4'b0011;
          wword = {2{wdata[15:0]}};
          ext   = ~is_unsigned & lane_sh[15];
          rdata = {{16{ext}}, lane_sh[15:0]};
        end
      end
      SZ_WORD: begin
        misaligned = |offset;
        if (offset == 2'b00) begin
          be    = 4'b1111;
          wword = wdata;
          rdata = lane_sh;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_unit.sv
// Single-outstanding-request data memory with byte/half/word access and a
// configurable read latency; errors return zero data with normal timing.
module data_memory_unit
  import mem_pkg::*;
#(
  parameter int DEPTH    = 128,
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = $clog2(DEPTH) + 2
) (
  input  logic clk,
  input  logic rst,
  mem_if.slave bus
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int LAT   = lat_clamp(READ_LAT);
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_INIT = (LAT >= 2) ? CNT_W'(LAT - 2) : '0;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_RESP = RESP;

  typedef logic [DEPTH-1:0][31:0] image_t;

  function automatic image_t image_init();
    image_t img;
    for (int i = 0; i < DEPTH; i++) img[i] = 32'(i);
    return img;
  endfunction

  // Power-up contents (word i holds i) come from the declaration, not from reset.
  image_t mem = image_init();

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      data_q;
  logic             err_q;

  logic [IDX_W-1:0] idx;
  logic [1:0]       offset;
  logic             range_err;
  logic             misaligned;
  logic             err;
  logic             accept;
  logic             do_write;
  logic [31:0]      rword;
  logic [31:0]      wword;
  logic [31:0]      ld_data;
  logic [3:0]       be;

  assign idx       = bus.req_addr[ADDR_W-1:2];
  assign offset    = bus.req_addr[1:0];
  assign range_err = |bus.req_addr[31:ADDR_W];
  assign rword     = mem[idx];
  assign err       = (bus.req_size == SZ_ILL) | misaligned | range_err;
  assign accept    = bus.req_valid & bus.req_ready;
  assign do_write  = accept & bus.req_we & ~err;

  mem_lane_align u_align (
    .size        (bus.req_size),
    .offset      (offset),
    .is_unsigned (bus.req_unsigned),
    .wdata       (bus.req_wdata),
    .rword       (rword),
    .be          (be),
    .wword       (wword),
    .rdata       (ld_data),
    .misaligned  (misaligned)
  );

  // NOTE: the storage array has no reset branch; contents must survive rst.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            data_q <= (bus.req_we || err) ? '0 : ld_data;
            err_q  <= err;
            cnt    <= CNT_INIT;
            state  <= (LAT == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_RESP;
          else           cnt   <= cnt - 1'b1;
        end
        S_RESP: begin
          if (bus.resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Ready is masked by rst so nothing can be accepted on a reset edge.
  assign bus.req_ready  = rst & (state == S_IDLE);
  assign bus.resp_valid = (state == S_RESP);
  assign bus.resp_rdata = bus.resp_valid ? data_q : '0;
  assign bus.resp_err   = bus.resp_valid & err_q;

endmodule
